// File: rtl/bk_sector_sequencer.sv
// Backup-RAM save/load sequencer: walks SECTORS sector requests over the sd_rd/sd_wr/sd_ack handshake.
// Optional autosave on OSD close is enabled by defining BK_AUTOSAVE_EN.
module bk_sector_sequencer #(
    parameter int SECTORS   = 128,
    parameter int SLOT_BITS = 2,
    parameter int TIMEOUT_W = 24
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 downloading,
    input  logic                 img_mounted,
    input  logic                 img_readonly,
    input  logic [63:0]          img_size,
    input  logic                 bk_load,
    input  logic                 bk_save,
    input  logic [SLOT_BITS-1:0] slot,
    input  logic                 sd_ack,
`ifdef BK_AUTOSAVE_EN
    input  logic                 bram_wr,
    input  logic                 osd_open,
`endif
    output logic [31:0]          sd_lba,
    output logic                 sd_rd,
    output logic                 sd_wr,
    output logic                 bk_ena,
    output logic                 bk_loading,
    output logic                 bk_busy,
    output logic                 bk_done,
    output logic                 bk_err
);
    localparam int IDX_W = $clog2(SECTORS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SECTORS - 1);

    typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

    state_t                 r_state;
    logic                   r_old_load, r_old_save, r_old_dl, r_old_ack;
    logic [SLOT_BITS-1:0]   r_slot;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_is_load;
    logic [TIMEOUT_W-1:0]   r_wdog;
    logic [31:0]            r_sd_lba;
    logic                   r_sd_rd, r_sd_wr, r_bk_ena, r_bk_loading, r_bk_busy, r_bk_done, r_bk_err;

    logic                   w_load_rise, w_save_rise, w_dl_rise, w_ack_rise, w_ack_fall;
    logic                   w_mount_ok, w_start, w_auto_start;
    logic [IDX_W-1:0]       w_idx_next;
    logic [TIMEOUT_W-1:0]   w_wdog_inc;
    logic                   w_wdog_expire;

    assign w_load_rise   = bk_load & ~r_old_load;
    assign w_save_rise   = bk_save & ~r_old_save;
    assign w_dl_rise     = downloading & ~r_old_dl;
    assign w_ack_rise    = sd_ack & ~r_old_ack;
    assign w_ack_fall    = ~sd_ack & r_old_ack;
    assign w_mount_ok    = downloading & img_mounted & (img_size != 64'd0) & ~img_readonly;
    assign w_start       = (r_state == IDLE) &
                           ((r_bk_ena & (w_load_rise | w_save_rise)) | w_auto_start);
    assign w_idx_next    = r_idx + 1'b1;
    assign w_wdog_inc    = r_wdog + 1'b1;
    // Expire on the cycle the counter would reach all-ones.
    assign w_wdog_expire = &w_wdog_inc;

`ifdef BK_AUTOSAVE_EN
    logic r_dirty, r_old_osd;

    // Manual triggers are evaluated first in w_start; autosave only ever requests a save.
    assign w_auto_start = ~osd_open & r_old_osd & r_dirty & r_bk_ena & (r_state == IDLE);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_dirty   <= 1'b0;
            r_old_osd <= 1'b0;
        end else begin
            r_old_osd <= osd_open;
            if (w_start)
                r_dirty <= 1'b0;
            else if (bram_wr)
                r_dirty <= 1'b1;
        end
    end
`else
    assign w_auto_start = 1'b0;
`endif

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_old_load   <= 1'b0;
            r_old_save   <= 1'b0;
            r_old_dl     <= 1'b0;
            r_old_ack    <= 1'b0;
            r_slot       <= '0;
            r_idx        <= '0;
            r_is_load    <= 1'b0;
            r_wdog       <= '0;
            r_sd_lba     <= '0;
            r_sd_rd      <= 1'b0;
            r_sd_wr      <= 1'b0;
            r_bk_ena     <= 1'b0;
            r_bk_loading <= 1'b0;
            r_bk_busy    <= 1'b0;
            r_bk_done    <= 1'b0;
            r_bk_err     <= 1'b0;
        end else begin
            r_old_load <= bk_load;
            r_old_save <= bk_save;
            r_old_dl   <= downloading;
            r_old_ack  <= sd_ack;
            r_bk_done  <= 1'b0;

            if (w_mount_ok)
                r_bk_ena <= 1'b1;
            else if (w_dl_rise)
                r_bk_ena <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_slot       <= slot;
                        r_idx        <= '0;
                        r_is_load    <= w_load_rise;
                        r_sd_lba     <= 32'({slot, {IDX_W{1'b0}}});
                        r_sd_rd      <= w_load_rise;
                        r_sd_wr      <= ~w_load_rise;
                        r_bk_loading <= w_load_rise;
                        r_bk_busy    <= 1'b1;
                        r_bk_err     <= 1'b0;
                        r_wdog       <= '0;
                        r_state      <= REQ;
                    end
                end
                REQ, XFER: begin
                    if (w_dl_rise || (!(w_ack_rise || w_ack_fall) && w_wdog_expire)) begin
                        // New download or stalled HPS: drop everything, only the watchdog flags it.
                        r_bk_err     <= ~w_dl_rise;
                        r_sd_rd      <= 1'b0;
                        r_sd_wr      <= 1'b0;
                        r_bk_loading <= 1'b0;
                        r_bk_busy    <= 1'b0;
                        r_wdog       <= '0;
                        r_state      <= IDLE;
                    end else if (r_state == REQ && w_ack_rise) begin
                        r_sd_rd <= 1'b0;
                        r_sd_wr <= 1'b0;
                        r_wdog  <= '0;
                        r_state <= XFER;
                    end else if (r_state == XFER && w_ack_fall) begin
                        r_wdog <= '0;
                        if (r_idx == LAST_IDX) begin
                            r_bk_done    <= 1'b1;
                            r_bk_loading <= 1'b0;
                            r_bk_busy    <= 1'b0;
                            r_state      <= IDLE;
                        end else begin
                            r_idx    <= w_idx_next;
                            r_sd_lba <= 32'({r_slot, w_idx_next});
                            r_sd_rd  <= r_is_load;
                            r_sd_wr  <= ~r_is_load;
                            r_state  <= REQ;
                        end
                    end else if (w_ack_rise || w_ack_fall) begin
                        r_wdog <= '0;
                    end else begin
                        r_wdog <= w_wdog_inc;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign sd_lba     = r_sd_lba;
    assign sd_rd      = r_sd_rd;
    assign sd_wr      = r_sd_wr;
    assign bk_ena     = r_bk_ena;
    assign bk_loading = r_bk_loading;
    assign bk_busy    = r_bk_busy;
    assign bk_done    = r_bk_done;
    assign bk_err     = r_bk_err;
endmodule

// File: doc/bk_sector_sequencer.md
Name: bk_sector_sequencer

Overview:
Controller for the backup-RAM save/load path between the HPS virtual SD interface and the cartridge backup RAM.
- Gates availability (bk_ena) from image-mount events during ROM download.
- On a load or save trigger, issues SECTORS consecutive sector read/write requests through the sd_rd/sd_wr/sd_ack handshake.
- Holds bk_loading high for the duration of a load so the top level keeps the system in reset.
- Adds a per-sector ack timeout and abort-on-new-download.

Parameters:
SECTORS, 128, sectors per slot; power of 2, ≥2.
SLOT_BITS, 2, width of save-slot select.
TIMEOUT_W, 24, width of the per-handshake-phase watchdog counter.

Ports:
clk_sys  in  1  system clock
reset  in  1  asynchronous, active-high reset
downloading  in  1  ROM download in progress (ioctl_download)
img_mounted  in  1  one-cycle pulse: save image mounted
img_readonly  in  1  mounted image is read-only
img_size  in  64  mounted image size in bytes
bk_load  in  1  level; rising edge requests load
bk_save  in  1  level; rising edge requests save
slot  in  SLOT_BITS  save slot, sampled at start
sd_ack  in  1  HPS acknowledge; high during a sector transfer
sd_lba  out  32  sector address
sd_rd  out  1  sector read request
sd_wr  out  1  sector write request
bk_ena  out  1  backup save/load available
bk_loading  out  1  load in progress
bk_busy  out  1  any transfer in progress
bk_done  out  1  one-cycle pulse: all sectors transferred
bk_err  out  1  sticky: last transfer aborted by timeout

Behaviour:
- Reset values: all outputs 0. FSM state IDLE. Edge-detect registers cleared to 0.
- Edge detect: registered old_* copies of bk_load, bk_save, downloading and sd_ack. A rise is cur=1 & old=0.
- bk_ena:
  - Cleared on a downloading rise.
  - Set when downloading & img_mounted & (img_size≠0) & ~img_readonly.
  - If both happen in the same cycle, set wins.
- FSM states: IDLE, REQ, XFER.
- IDLE:
  - Start condition: bk_ena & (bk_load rise | bk_save rise).
  - If both rise in the same cycle, load wins.
  - On start, in the next cycle:
    - latch slot;
    - sector index idx=0;
    - sd_lba = {zero-pad, slot, idx} where idx is log2(SECTORS) bits;
    - sd_rd = is_load, sd_wr = ~is_load;
    - bk_loading = is_load, bk_busy=1, bk_err=0;
    - go to REQ.
- REQ:
  - On sd_ack rise: clear sd_rd and sd_wr, go to XFER.
- XFER:
  - On sd_ack fall, if idx == SECTORS-1: bk_done=1 for one cycle, bk_loading=0, bk_busy=0, go to IDLE.
  - On sd_ack fall otherwise: idx+1, update sd_lba, re-assert the same request in that same edge, go to REQ.
- Latency: from the sd_ack fall to the next request asserting is 1 clock.
- Triggers while busy: load/save rises are ignored, not queued.
- Watchdog:
  - Counter clears on state entry and on each sd_ack edge; it increments in REQ/XFER.
  - At all-ones: set bk_err, drop sd_rd/sd_wr, clear bk_loading/bk_busy, go to IDLE. No bk_done.
- Download start while busy: same abort as the watchdog, but bk_err is not set. bk_ena also clears.
- sd_lba holds its last value in IDLE.
- Reset mid-transfer: all outputs return to reset values asynchronously.

Optional Feature:
Macro name: BK_AUTOSAVE_EN.
- With the macro defined, two ports are added:
  - bram_wr (in, 1): backup RAM written by the core;
  - osd_open (in, 1): OSD menu visible.
- A dirty flag is set by bram_wr and cleared at the start of any save or load.
- A falling edge of osd_open with dirty & bk_ena & IDLE starts a save exactly as a bk_save rise does.
- If a manual trigger occurs in the same cycle, the manual trigger has priority.
- Without the macro defined: no extra ports, no dirty flag, behaviour exactly as above.

Test Plan:
1. Mount gating: downloading=1, img_mounted pulse with size=8192, readonly=0 → bk_ena=1. Then a downloading rise → bk_ena=0. Repeat with readonly=1 → bk_ena stays 0.
2. Full load, slot=2, bk_ena=1, bk_load rise; model acks 20 clocks high after a 5-clock delay:
   - first request is sd_rd=1 with sd_lba=0x100;
   - 128 requests total, last at sd_lba=0x17F;
   - bk_loading high throughout; bk_done pulses once after the last ack fall; sd_wr never high.
3. Save, slot=0, with simultaneous bk_load and bk_save rises → load wins (sd_rd=1). A separate save-only run produces sd_wr requests at sd_lba 0..127.
4. Timeout, TIMEOUT_W=4: sd_ack never asserted → after 15 clocks in REQ, bk_err=1, sd_rd=0, bk_busy=0, no bk_done. A new bk_load rise clears bk_err.
5. Abort: downloading rises during sector 40 of a save → sd_wr=0, bk_busy=0, bk_ena=0, bk_err=0. A subsequent bk_save rise is ignored.
6. Busy re-trigger and reset: a bk_save rise during a load is ignored (sd_wr never set). Async reset asserted mid-XFER → all outputs 0 immediately, with no clock edge needed.
